multiport_word_memory: RTL and testbench
========================================

# multiport_word_memory

Parametrised, word-organised, byte-addressed RAM with NUM_PORTS independent read/write ports, per-byte write enables, deterministic write-conflict resolution and selectable read latency. Contents are cleared by a post-reset init sweep, one word per cycle, instead of a single-cycle array reset; `ready` reports completion. It replaces the fixed two-port, 4-byte, 256-byte data memory used by the processor datapath and testbenches.

## Interface
- NUM_PORTS, 2: number of independent ports (1..8).
- WORD_BYTES, 4: bytes per word; power of two.
- DEPTH_BYTES, 256: capacity in bytes; multiple of WORD_BYTES.
- ADDR_W, 32: address width.
- READ_LATENCY, 0: 0 = combinational read; 1 = registered read.

Derived: DEPTH_WORDS = DEPTH_BYTES/WORD_BYTES; OFF_W = log2(WORD_BYTES).

- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- addr  in  [NUM_PORTS][ADDR_W]  byte address per port.
- wdata  in  [NUM_PORTS][WORD_BYTES*8]  write word per port; byte k is bits [8k+7:8k].
- be  in  [NUM_PORTS][WORD_BYTES]  per-byte write enable.
- we  in  [NUM_PORTS]  port write request.
- rdata  out  [NUM_PORTS][WORD_BYTES*8]  read word per port.
- err  out  [NUM_PORTS]  address out of range; follows rdata timing.
- conflict  out  1  registered; two or more ports wrote the same byte in the previous cycle.
- ready  out  1  init sweep complete; access permitted.

## Operation
- Effective word index per port: addr >> OFF_W. Low OFF_W bits are ignored, so access is always aligned.
- Out of range, meaning addr >= DEPTH_BYTES: the write is dropped, rdata is 0 and err is 1.
- Write occurs on a rising edge when `ready & we[p]`. Byte k of word w is written only where `be[p][k]` is 1.
- Conflicts: if several ports write the same byte in one cycle, the highest port index wins, resolved per byte. Disjoint byte enables to the same word merge. `conflict` is 1 for one cycle afterwards.
- Read is read-first. A read of a word being written in the same cycle returns the pre-write contents.
- FSM states:
  - INIT: counter `clr_idx` runs 0..DEPTH_WORDS-1, writing 0 to word `clr_idx` each cycle. Port writes are ignored, reads return 0 and err is 0. At `clr_idx == DEPTH_WORDS-1`, move to RUN.
  - RUN: normal operation. RUN is left only by reset.
- Reset asserted at any time, including mid-init, sends the FSM to INIT with `clr_idx` at 0, and the sweep restarts on release.
- Memory array has no reset term, so it maps to RAM. Only the FSM, counter and output registers are reset.
- Reset values: ready 0, conflict 0, `clr_idx` 0. With READ_LATENCY=1, rdata is 0 and err is 0.

## Timing
- Init takes DEPTH_WORDS cycles after the first rising edge with rst_b high. `ready` rises on the edge that performs the last clear; for the defaults, that is the 64th edge.
- READ_LATENCY=0: rdata and err are combinational from addr and current contents. A write is visible on the following cycle.
- READ_LATENCY=1: addr is sampled at edge N, and rdata/err are valid after edge N. Data equals contents before edge-N writes.
- `conflict` is asserted after edge N for conflicts at edge N, and lasts one cycle.
- A write accepted at edge N is readable by any port from cycle N+1 (latency 0) or after edge N+1 (latency 1).

## Structure
- Package `memory_pkg`:
  - `mem_state_t` enum {INIT, RUN};
  - helper function `word_index(addr, OFF_W)`;
  - default-parameter constants.
- Sub-module `mem_init_sequencer`: FSM plus `clr_idx` counter, producing `ready`, `clr_we` and `clr_idx`.
- Top level contains the array, the per-byte priority-merge write logic, the read path with the optional output register, and range checks.

## Test plan
- Reset, then run 63 edges: ready=0 and a read of addr 0x10 returns 0. On the 64th edge ready=1.
- Init interruption: preload via ports, assert rst_b low at clr_idx=20, then release. Exactly 64 further edges before ready=1, and every word reads 0.
- Byte enables: write 0xAABBCCDD with be=4'b0101 to addr 0x20. Port 1 reads 0x00BB00DD.
- Conflict: port0 writes 0x11111111 with be=1111 and port1 writes 0x22222222 with be=0011, both to 0x40. Result is 0x11112222 and conflict=1 for exactly one cycle.
- Range and alignment: a write to 0x103 is dropped and err=1. A write to 0x07 lands at word 1; a read of 0x04 returns that data.
- READ_LATENCY=1 read-first: word 0x80 holds 0x5. Write 0x9 and read the same address at edge N. rdata=0x5 after N and 0x9 after N+1.

Source files
------------

// File: rtl/multiport_word_memory_pkg.sv
// memory_pkg: shared state type, default sizing and address helpers for multiport_word_memory.
package memory_pkg;
    typedef enum logic {INIT, RUN} mem_state_t;
    localparam int DEF_NUM_PORTS    = 2;
    localparam int DEF_WORD_BYTES   = 4;
    localparam int DEF_DEPTH_BYTES  = 256;
    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_READ_LATENCY = 0;
    function automatic logic [63:0] word_index(input logic [63:0] addr, input int off_w);
        return addr >> off_w;
    endfunction
endpackage

// File: rtl/multiport_word_memory_if.sv
// multiport_word_memory_if: per-port request/response bundle plus memory status.
interface multiport_word_memory_if import memory_pkg::*; #(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int ADDR_W     = DEF_ADDR_W
);
    logic [NUM_PORTS-1:0][ADDR_W-1:0]       addr;
    logic [NUM_PORTS-1:0][WORD_BYTES*8-1:0] wdata;
    logic [NUM_PORTS-1:0][WORD_BYTES-1:0]   be;
    logic [NUM_PORTS-1:0]                   we;
    logic [NUM_PORTS-1:0][WORD_BYTES*8-1:0] rdata;
    logic [NUM_PORTS-1:0]                   err;
    logic                                   conflict;
    logic                                   ready;
    modport master (output addr, wdata, be, we, input rdata, err, conflict, ready);
    modport slave (input addr, wdata, be, we, output rdata, err, conflict, ready);
endinterface

// File: rtl/multiport_word_memory_init_sequencer.sv
// mem_init_sequencer: after reset sweeps every word to zero, one per cycle, then raises ready.
module mem_init_sequencer import memory_pkg::*; #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    output logic             ready,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx
);
    mem_state_t state;
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            state   <= INIT;
            clr_idx <= '0;
            ready   <= 1'b0;
            clr_we  <= 1'b1;
        end else if (state == INIT) begin
            if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                state  <= RUN;
                ready  <= 1'b1;
                clr_we <= 1'b0;
            end else
                clr_idx <= clr_idx + 1'b1;
        end
endmodule

// File: rtl/multiport_word_memory.sv
// multiport_word_memory: byte-addressed word RAM with N ports, byte enables,
// highest-port-wins per-byte merge, read-first reads and optional output register.
module multiport_word_memory import memory_pkg::*; #(
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int WORD_BYTES   = DEF_WORD_BYTES,
    parameter int DEPTH_BYTES  = DEF_DEPTH_BYTES,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input logic                   clk,
    input logic                   rst_b,
    multiport_word_memory_if.slave bus
);
    localparam int DW          = WORD_BYTES * 8;
    localparam int DEPTH_WORDS = DEPTH_BYTES / WORD_BYTES;
    localparam int OFF_W       = $clog2(WORD_BYTES);
    localparam int IDX_W       = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    logic [DW-1:0]                   mem [DEPTH_WORDS];
    logic                            ready, clr_we, conf_n;
    logic [IDX_W-1:0]                clr_idx;
    logic [NUM_PORTS-1:0]            in_range, wr, err_n;
    logic [NUM_PORTS-1:0][IDX_W-1:0] widx;
    logic [NUM_PORTS-1:0][DW-1:0]    rd_n;

    mem_init_sequencer #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_seq (
        .clk(clk), .rst_b(rst_b), .ready(ready), .clr_we(clr_we), .clr_idx(clr_idx)
    );

    assign bus.ready = ready;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_range[p] = 64'(bus.addr[p]) < 64'(DEPTH_BYTES);
            widx[p]     = IDX_W'(word_index(64'(bus.addr[p]), OFF_W));
            wr[p]       = ready && bus.we[p] && in_range[p];
            rd_n[p]     = (ready && in_range[p]) ? mem[widx[p]] : '0;
            err_n[p]    = ready && !in_range[p];
        end
    end

    // Later ports overwrite earlier ones byte by byte, so the highest index wins.
    for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_word
        logic [DW-1:0] nxt;
        logic          wen;
        always_comb begin
            nxt = mem[w];
            wen = 1'b0;
            if (clr_we && clr_idx == IDX_W'(w)) begin
                nxt = '0;
                wen = 1'b1;
            end
            for (int p = 0; p < NUM_PORTS; p++)
                for (int k = 0; k < WORD_BYTES; k++)
                    if (wr[p] && widx[p] == IDX_W'(w) && bus.be[p][k]) begin
                        nxt[8*k+:8] = bus.wdata[p][8*k+:8];
                        wen         = 1'b1;
                    end
        end
        always_ff @(posedge clk)
            if (wen) mem[w] <= nxt;
    end

    always_comb begin
        conf_n = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++)
            for (int q = p + 1; q < NUM_PORTS; q++)
                if (wr[p] && wr[q] && widx[p] == widx[q] && |(bus.be[p] & bus.be[q]))
                    conf_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) bus.conflict <= 1'b0;
        else        bus.conflict <= conf_n;

    if (READ_LATENCY == 1) begin : g_reg
        always_ff @(posedge clk or negedge rst_b)
            if (!rst_b) begin
                bus.rdata <= '0;
                bus.err   <= '0;
            end else begin
                bus.rdata <= rd_n;
                bus.err   <= err_n;
            end
    end else begin : g_comb
        assign bus.rdata = rd_n;
        assign bus.err   = err_n;
    end
endmodule

// File: tb/tb_multiport_word_memory.sv
// tb_multiport_word_memory: directed vectors against a latency-0 and a latency-1 instance.
module tb_multiport_word_memory;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;

    multiport_word_memory_if #(.NUM_PORTS(2), .WORD_BYTES(4), .ADDR_W(32)) i0 ();
    multiport_word_memory_if #(.NUM_PORTS(2), .WORD_BYTES(4), .ADDR_W(32)) i1 ();

    multiport_word_memory #(.NUM_PORTS(2), .WORD_BYTES(4), .DEPTH_BYTES(256), .ADDR_W(32),
                            .READ_LATENCY(0)) u0 (.clk(clk), .rst_b(rst_b), .bus(i0.slave));
    multiport_word_memory #(.NUM_PORTS(2), .WORD_BYTES(4), .DEPTH_BYTES(256), .ADDR_W(32),
                            .READ_LATENCY(1)) u1 (.clk(clk), .rst_b(rst_b), .bus(i1.slave));

    typedef struct {
        logic [31:0] a0, d0; logic [3:0] b0; logic w0;
        logic [31:0] a1, d1; logic [3:0] b1; logic w1;
        logic [31:0] r0, r1; logic e0, e1, c;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0]  = '{32'h20, 32'hAABBCCDD, 4'h5, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h40, 32'h0, 4'h0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0, 32'h00BB00DD, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h40, 32'h11111111, 4'hF, 1'b1, 32'h40, 32'h22222222, 4'h3, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h40, 32'h0, 4'h0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h11112222, 32'h11112222, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h103, 32'h12345678, 4'hF, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h07, 32'hCAFEF00D, 4'hF, 1'b1, 32'h00, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h00, 32'h0, 4'h0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h30, 32'hA1A2A3A4, 4'hC, 1'b1, 32'h31, 32'hB1B2B3B4, 4'h3, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h30, 32'h0, 4'h0, 1'b0, 32'h07, 32'h0, 4'h0, 1'b0, 32'hA1A2B3B4, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h30, 32'hFFFFFFFF, 4'h0, 1'b1, 32'hFC, 32'h0, 4'h0, 1'b0, 32'hA1A2B3B4, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h30, 32'h0, 4'h0, 1'b0, 32'h10000000, 32'h0, 4'h0, 1'b0, 32'hA1A2B3B4, 32'h0, 1'b0, 1'b1, 1'b0};
        i0.addr = '0; i0.wdata = '0; i0.be = '0; i0.we = '0;
        i1.addr = '0; i1.wdata = '0; i1.be = '0; i1.we = '0;
        #2;
        chk("reset ready", i0.ready, 1'b0);
        chk("reset conflict", i0.conflict, 1'b0);
        chk("reset lat1 rdata", i1.rdata, 64'h0);
        chk("reset lat1 err", i1.err, 2'b00);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (63) tick();
        i0.addr[0] = 32'h10;
        #1;
        chk("init ready after 63", i0.ready, 1'b0);
        chk("init read 0x10", i0.rdata[0], 32'h0);
        chk("init err", i0.err[0], 1'b0);
        tick();
        chk("ready after 64", i0.ready, 1'b1);
        chk("lat1 ready after 64", i1.ready, 1'b1);

        for (int i = 0; i < 11; i++) begin
            i0.addr[0] = vecs[i].a0; i0.wdata[0] = vecs[i].d0; i0.be[0] = vecs[i].b0; i0.we[0] = vecs[i].w0;
            i0.addr[1] = vecs[i].a1; i0.wdata[1] = vecs[i].d1; i0.be[1] = vecs[i].b1; i0.we[1] = vecs[i].w1;
            #1;
            chk($sformatf("v%0d rdata0", i), i0.rdata[0], vecs[i].r0);
            chk($sformatf("v%0d rdata1", i), i0.rdata[1], vecs[i].r1);
            chk($sformatf("v%0d err0", i), i0.err[0], vecs[i].e0);
            chk($sformatf("v%0d err1", i), i0.err[1], vecs[i].e1);
            chk($sformatf("v%0d conflict", i), i0.conflict, vecs[i].c);
            tick();
        end
        i0.we = '0;

        i1.addr[0] = 32'h80; i1.wdata[0] = 32'h5; i1.be[0] = 4'hF; i1.we[0] = 1'b1;
        tick();
        chk("lat1 preload read-first", i1.rdata[0], 32'h0);
        i1.wdata[0] = 32'h9;
        tick();
        chk("lat1 edge N old data", i1.rdata[0], 32'h5);
        i1.we[0] = 1'b0;
        tick();
        chk("lat1 edge N+1 new data", i1.rdata[0], 32'h9);
        i1.addr[0] = 32'h200;
        #1;
        chk("lat1 err before edge", i1.err[0], 1'b0);
        tick();
        chk("lat1 err after edge", i1.err[0], 1'b1);
        chk("lat1 oor rdata", i1.rdata[0], 32'h0);

        i0.addr[0] = 32'h14; i0.wdata[0] = 32'hDEADBEEF; i0.be[0] = 4'hF; i0.we[0] = 1'b1;
        tick();
        i0.we[0] = 1'b0;
        #1;
        chk("preload word 5", i0.rdata[0], 32'hDEADBEEF);
        rst_b = 1'b0;
        #1;
        chk("async reset ready", i0.ready, 1'b0);
        rst_b = 1'b1;
        i0.wdata[0] = 32'hFFFFFFFF; i0.we[0] = 1'b1; i0.addr[1] = 32'h300;
        repeat (20) tick();
        chk("mid-init err ignored", i0.err[1], 1'b0);
        chk("mid-init read zero", i0.rdata[0], 32'h0);
        rst_b = 1'b0;
        #1;
        rst_b = 1'b1;
        n = 0;
        while (!i0.ready && n < 200) begin
            tick();
            n++;
        end
        chk("restart edges to ready", n, 64);
        i0.we[0] = 1'b0;
        for (int w = 0; w < 64; w++) begin
            i0.addr[0] = 32'(w * 4);
            #1;
            chk($sformatf("cleared word %0d", w), i0.rdata[0], 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
